// File: rtl/ssd_pkg.sv
// +----------------------------------------------------------------------+
// | ssd_pkg: glyph constants and default parameters for the SSD driver.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package ssd_pkg;

  localparam int c_DEFAULT_NUM_DIGITS = 4;
  localparam int c_DEFAULT_DIV_BITS   = 16;

  typedef logic [7:0] seg_t;

  // Active-low a..g in bits 7..1; bit 0 (dp) is left off in every glyph.
  localparam seg_t c_GLYPH_0     = 8'h03;
  localparam seg_t c_GLYPH_1     = 8'h9F;
  localparam seg_t c_GLYPH_2     = 8'h25;
  localparam seg_t c_GLYPH_3     = 8'h0D;
  localparam seg_t c_GLYPH_4     = 8'h99;
  localparam seg_t c_GLYPH_5     = 8'h49;
  localparam seg_t c_GLYPH_6     = 8'h41;
  localparam seg_t c_GLYPH_7     = 8'h1F;
  localparam seg_t c_GLYPH_8     = 8'h01;
  localparam seg_t c_GLYPH_9     = 8'h09;
  localparam seg_t c_GLYPH_A     = 8'h11;
  localparam seg_t c_GLYPH_B     = 8'hC1;
  localparam seg_t c_GLYPH_C     = 8'h63;
  localparam seg_t c_GLYPH_D     = 8'h85;
  localparam seg_t c_GLYPH_E     = 8'h61;
  localparam seg_t c_GLYPH_F     = 8'h71;
  localparam seg_t c_GLYPH_BLANK = 8'hFF;

  function automatic seg_t apply_dp(input seg_t glyph, input logic dp);
    return {glyph[7:1], ~dp};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ssd_glyph_decode.sv
// +----------------------------------------------------------------------+
// | ssd_glyph_decode: nibble/dp/blank to active-low segments (comb).     |
// | SSD_HEX_EN defined shows A-F; otherwise 10-15 show the F error glyph.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module ssd_glyph_decode
  import ssd_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  seg_t w_glyph;

  always_comb begin
    w_glyph = c_GLYPH_F;
    case (nibble_i)
      4'h0: w_glyph = c_GLYPH_0;
      4'h1: w_glyph = c_GLYPH_1;
      4'h2: w_glyph = c_GLYPH_2;
      4'h3: w_glyph = c_GLYPH_3;
      4'h4: w_glyph = c_GLYPH_4;
      4'h5: w_glyph = c_GLYPH_5;
      4'h6: w_glyph = c_GLYPH_6;
      4'h7: w_glyph = c_GLYPH_7;
      4'h8: w_glyph = c_GLYPH_8;
      4'h9: w_glyph = c_GLYPH_9;
`ifdef SSD_HEX_EN
      4'hA: w_glyph = c_GLYPH_A;
      4'hB: w_glyph = c_GLYPH_B;
      4'hC: w_glyph = c_GLYPH_C;
      4'hD: w_glyph = c_GLYPH_D;
      4'hE: w_glyph = c_GLYPH_E;
`endif
      default: w_glyph = c_GLYPH_F;
    endcase
  end

  // Blanking overrides the decimal point as well.
  assign seg_o = blank_i ? c_GLYPH_BLANK : apply_dp(w_glyph, dp_i);

endmodule

`default_nettype wire

// File: rtl/ssd_scan_driver.sv
// +----------------------------------------------------------------------+
// | ssd_scan_driver: multiplexed 7-segment scanner with tear-free load.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS = c_DEFAULT_NUM_DIGITS,
  parameter int DIV_BITS   = c_DEFAULT_DIV_BITS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [NUM_DIGITS-1:0]   ssd_ctl,
  output logic [7:0]              D_ssd,
  output logic                    frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_BITS-1:0]             div_q, div_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic                            pending_q, pending_d;
  logic [NUM_DIGITS-1:0][3:0]      shd_data_q, shd_data_d;
  logic [NUM_DIGITS-1:0]           shd_dp_q, shd_dp_d;
  logic [NUM_DIGITS-1:0]           shd_blank_q, shd_blank_d;
  logic [NUM_DIGITS-1:0][3:0]      act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0]           act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]           act_blank_q, act_blank_d;
  logic [NUM_DIGITS-1:0]           ssd_ctl_q, ssd_ctl_d;
  logic [7:0]                      d_ssd_q, d_ssd_d;
  logic                            frame_start_q, frame_start_d;

  logic                            w_tick;
  logic                            w_boundary;
  logic [NUM_DIGITS-1:0]           w_sel;
  logic [7:0]                      w_seg;

  assign w_tick     = &div_q;
  assign w_boundary = w_tick && (idx_q == c_LAST_IDX);

  ssd_glyph_decode u_decode (
    .nibble_i (act_data_q[idx_q]),
    .dp_i     (act_dp_q[idx_q]),
    .blank_i  (act_blank_q[idx_q]),
    .seg_o    (w_seg)
  );

  always_comb begin
    div_d       = div_q + 1'b1;
    idx_d       = idx_q;
    pending_d   = pending_q;
    shd_data_d  = shd_data_q;
    shd_dp_d    = shd_dp_q;
    shd_blank_d = shd_blank_q;
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;

    if (w_tick) begin
      idx_d = (idx_q == c_LAST_IDX) ? '0 : idx_q + 1'b1;
    end

    if (load) begin
      shd_data_d  = data_in;
      shd_dp_d    = dp_in;
      shd_blank_d = blank_in;
      pending_d   = 1'b1;
    end

    // A load landing on the boundary bypasses the shadow so it is not lost.
    if (w_boundary) begin
      if (load) begin
        act_data_d  = data_in;
        act_dp_d    = dp_in;
        act_blank_d = blank_in;
      end else if (pending_q) begin
        act_data_d  = shd_data_q;
        act_dp_d    = shd_dp_q;
        act_blank_d = shd_blank_q;
      end
      pending_d = 1'b0;
    end

    w_sel        = '0;
    w_sel[idx_q] = 1'b1;
    ssd_ctl_d     = ~w_sel;
    d_ssd_d       = w_seg;
    frame_start_d = w_boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      idx_q         <= '0;
      pending_q     <= 1'b0;
      shd_data_q    <= '0;
      shd_dp_q      <= '0;
      shd_blank_q   <= '1;
      act_data_q    <= '0;
      act_dp_q      <= '0;
      act_blank_q   <= '1;
      ssd_ctl_q     <= '1;
      d_ssd_q       <= c_GLYPH_BLANK;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      shd_data_q    <= shd_data_d;
      shd_dp_q      <= shd_dp_d;
      shd_blank_q   <= shd_blank_d;
      act_data_q    <= act_data_d;
      act_dp_q      <= act_dp_d;
      act_blank_q   <= act_blank_d;
      ssd_ctl_q     <= ssd_ctl_d;
      d_ssd_q       <= d_ssd_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign ssd_ctl     = ssd_ctl_q;
  assign D_ssd       = d_ssd_q;
  assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_ssd_scan_driver.sv
// +----------------------------------------------------------------------+
// | tb_ssd_scan_driver: directed self-checking bench, 1/4/8 digit DUTs.  |
// | Hex expectation follows SSD_HEX_EN. Rev 1.0                          |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_ssd_scan_driver;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        load     = 1'b0;
  logic [15:0] data_in  = '0;
  logic [3:0]  dp_in    = '0;
  logic [3:0]  blank_in = '0;
  logic [3:0]  ssd_ctl;
  logic [7:0]  d_ssd;
  logic        frame_start;

  logic        idle_load = 1'b0;
  logic [3:0]  d1_data   = '0;
  logic        d1_dp     = 1'b0;
  logic        d1_blank  = 1'b0;
  logic        d1_ctl;
  logic [7:0]  d1_seg;
  logic        d1_fs;
  logic [31:0] d8_data   = '0;
  logic [7:0]  d8_dp     = '0;
  logic [7:0]  d8_blank  = '0;
  logic [7:0]  d8_ctl;
  logic [7:0]  d8_seg;
  logic        d8_fs;

  int n      = 0;
  int checks = 0;
  int errors = 0;

  logic [3:0] exp4;
  logic [7:0] exp8;
  logic [7:0] hex_b_exp;

  always #5 clk = ~clk;

  // Rising edges seen since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  ssd_scan_driver #(.NUM_DIGITS(4), .DIV_BITS(2)) u_dut (
    .clk (clk), .rst_n (rst_n), .load (load), .data_in (data_in),
    .dp_in (dp_in), .blank_in (blank_in), .ssd_ctl (ssd_ctl),
    .D_ssd (d_ssd), .frame_start (frame_start)
  );

  ssd_scan_driver #(.NUM_DIGITS(1), .DIV_BITS(2)) u_dut1 (
    .clk (clk), .rst_n (rst_n), .load (idle_load), .data_in (d1_data),
    .dp_in (d1_dp), .blank_in (d1_blank), .ssd_ctl (d1_ctl),
    .D_ssd (d1_seg), .frame_start (d1_fs)
  );

  ssd_scan_driver #(.NUM_DIGITS(8), .DIV_BITS(2)) u_dut8 (
    .clk (clk), .rst_n (rst_n), .load (idle_load), .data_in (d8_data),
    .dp_in (d8_dp), .blank_in (d8_blank), .ssd_ctl (d8_ctl),
    .D_ssd (d8_seg), .frame_start (d8_fs)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  task automatic wait_for(input int target);
    int guard = 0;
    while (n != target && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (n != target) check("wait_timeout", n, target);
  endtask

  task automatic expect_digit(input string tag, input logic [3:0] ctl, input logic [7:0] seg);
    check({tag, "_ctl"}, ssd_ctl, ctl);
    check({tag, "_seg"}, d_ssd, seg);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    load     = 1'b1;
    data_in  = d;
    dp_in    = dp;
    blank_in = bl;
    @(negedge clk);
    load     = 1'b0;
    data_in  = 16'hFFFF;
    dp_in    = 4'hF;
    blank_in = 4'h0;
  endtask

  initial begin
`ifdef SSD_HEX_EN
    hex_b_exp = 8'hC1;
`else
    hex_b_exp = 8'h71;
`endif

    repeat (3) @(negedge clk);
    check("rst_ctl", ssd_ctl, 4'hF);
    check("rst_seg", d_ssd, 8'hFF);
    check("rst_fs", frame_start, 1'b0);
    check("rst_ctl1", d1_ctl, 1'b1);
    check("rst_ctl8", d8_ctl, 8'hFF);
    rst_n = 1'b1;

    // Free scan with nothing loaded: blank digits, one-hot-low rotation.
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      exp4 = ~(4'b0001 << (((n - 1) / 4) % 4));
      exp8 = ~(8'b0000_0001 << (((n - 1) / 4) % 8));
      check("scan_ctl4", ssd_ctl, exp4);
      check("scan_seg4", d_ssd, 8'hFF);
      check("scan_fs4", frame_start, (n % 16) == 0);
      check("scan_ctl1", d1_ctl, 1'b0);
      check("scan_fs1", d1_fs, (n % 4) == 0);
      check("scan_ctl8", d8_ctl, exp8);
      check("scan_fs8", d8_fs, (n % 32) == 0);
    end
    check("scan_seg1", d1_seg, 8'hFF);
    check("scan_seg8", d8_seg, 8'hFF);

    // Mid-frame load stays hidden until the next frame.
    wait_for(40);
    do_load(16'h1234, 4'b0001, 4'b0000);
    wait_for(44);
    expect_digit("tear_d2", 4'b1011, 8'hFF);
    wait_for(48);
    expect_digit("tear_d3", 4'b0111, 8'hFF);
    check("tear_fs", frame_start, 1'b1);
    wait_for(50);
    expect_digit("new_d0", 4'b1110, 8'h98);
    wait_for(54);
    expect_digit("new_d1", 4'b1101, 8'h0D);
    wait_for(58);
    expect_digit("new_d2", 4'b1011, 8'h25);
    wait_for(62);
    expect_digit("new_d3", 4'b0111, 8'h9F);

    // Load sampled on the boundary tick itself.
    wait_for(63);
    do_load(16'h5678, 4'b0000, 4'b0000);
    expect_digit("bnd_old_d3", 4'b0111, 8'h9F);
    wait_for(66);
    expect_digit("bnd_d0", 4'b1110, 8'h01);
    wait_for(78);
    expect_digit("bnd_d3", 4'b0111, 8'h49);

    // Two loads in one frame: only the second shows; blanked digit hides dp.
    wait_for(82);
    do_load(16'h9999, 4'b1111, 4'b0000);
    wait_for(86);
    do_load(16'h3210, 4'b1000, 4'b1000);
    wait_for(90);
    expect_digit("ovw_old_d2", 4'b1011, 8'h41);
    wait_for(98);
    expect_digit("ovw_d0", 4'b1110, 8'h03);
    wait_for(102);
    expect_digit("ovw_d1", 4'b1101, 8'h9F);
    wait_for(106);
    expect_digit("ovw_d2", 4'b1011, 8'h25);
    wait_for(110);
    expect_digit("ovw_blank_d3", 4'b0111, 8'hFF);

    // Nibble B depends on the hex build option.
    wait_for(113);
    do_load(16'h000B, 4'b0000, 4'b0000);
    wait_for(130);
    expect_digit("hex_b", 4'b1110, hex_b_exp);
    wait_for(134);
    expect_digit("hex_d1", 4'b1101, 8'h03);

    // Asynchronous reset with a load pending, between clock edges.
    wait_for(137);
    do_load(16'h8888, 4'b0000, 4'b0000);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ctl", ssd_ctl, 4'hF);
    check("arst_seg", d_ssd, 8'hFF);
    check("arst_fs", frame_start, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_for(2);
    expect_digit("post_d0", 4'b1110, 8'hFF);
    wait_for(16);
    check("post_fs", frame_start, 1'b1);
    wait_for(18);
    expect_digit("post_f1_d0", 4'b1110, 8'hFF);
    wait_for(26);
    expect_digit("post_f1_d2", 4'b1011, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
